// File: rtl/control_multicycle_if.sv
`default_nettype none
// ============================================================================
// Module      : control_multicycle_if
// Description : Opcode/handshake/control bundle between the multicycle control
//               unit (master) and the datapath and memories (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface control_multicycle_if;
    logic [6:0] inst_opcode;
    logic       inst_mem_ready;
    logic       data_mem_ready;

    logic       inst_mem_req;
    logic       ir_write_enable;
    logic       pc_write_enable;
    logic       jal_enable;
    logic       jalr_enable;
    logic       branch_enable;
    logic       data_mem_read_enable;
    logic       data_mem_write_enable;
    logic       regfile_write_enable;
    logic [1:0] mem_to_reg_sel;
    logic [1:0] alu_op;
    logic [1:0] alu_sel_src_a;
    logic       alu_sel_src_b;
    logic [2:0] state;
    logic       fault;

    modport master (
        input  inst_opcode, inst_mem_ready, data_mem_ready,
        output inst_mem_req, ir_write_enable, pc_write_enable,
               jal_enable, jalr_enable, branch_enable,
               data_mem_read_enable, data_mem_write_enable,
               regfile_write_enable, mem_to_reg_sel, alu_op,
               alu_sel_src_a, alu_sel_src_b, state, fault
    );

    modport slave (
        output inst_opcode, inst_mem_ready, data_mem_ready,
        input  inst_mem_req, ir_write_enable, pc_write_enable,
               jal_enable, jalr_enable, branch_enable,
               data_mem_read_enable, data_mem_write_enable,
               regfile_write_enable, mem_to_reg_sel, alu_op,
               alu_sel_src_a, alu_sel_src_b, state, fault
    );
endinterface
`default_nettype wire

// File: rtl/control_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : control_multicycle
// Description : Multicycle RV64I control FSM (fetch/decode/execute/mem/wb)
//               with memory ready handshakes. CONTROL_MULTICYCLE_FAULT_EN
//               enables illegal-opcode and memory-timeout faults.
// Revision    : 1.0 - initial release
// ============================================================================
module control_multicycle #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter bit          ENABLE_RV64  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    control_multicycle_if.master bus
);

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_imm_32 = 7'b0011011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_32     = 7'b0111011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    if ((MEM_WAIT_MAX < 1) || (MEM_WAIT_MAX > 255)) begin : g_wait_max_range
        $error("control_multicycle: MEM_WAIT_MAX must be in 1..255");
    end

    state_t     state_q, state_d;
    logic [6:0] opcode_q, opcode_d;

    logic       w_inst_mem_req;
    logic       w_ir_write_enable;
    logic       w_pc_write_enable;
    logic       w_jal_enable;
    logic       w_jalr_enable;
    logic       w_branch_enable;
    logic       w_data_mem_read_enable;
    logic       w_data_mem_write_enable;
    logic       w_regfile_write_enable;
    logic [1:0] w_mem_to_reg_sel;
    logic       w_alu_active;
    logic       w_fault;
    logic [1:0] w_alu_op;
    logic [1:0] w_alu_sel_src_a;
    logic       w_alu_sel_src_b;

    function automatic logic f_is_legal(input logic [6:0] op);
        case (op)
            c_op_load, c_op_imm, c_op_auipc, c_op_store, c_op_reg,
            c_op_lui, c_op_branch, c_op_jalr, c_op_jal: return 1'b1;
            c_op_imm_32, c_op_32:                       return ENABLE_RV64;
            default:                                    return 1'b0;
        endcase
    endfunction

`ifdef CONTROL_MULTICYCLE_FAULT_EN
    localparam logic [7:0] c_wait_max = 8'(MEM_WAIT_MAX);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       w_timeout;

    assign w_timeout = (wait_cnt_q == c_wait_max);

    // Counts only stalled cycles that stay in the same state; any move clears it.
    always_comb begin
        wait_cnt_d = 8'd0;
        if ((state_d == state_q) &&
            (((state_q == S_FETCH) && !bus.inst_mem_ready) ||
             ((state_q == S_MEM)   && !bus.data_mem_ready))) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= 7'd0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        w_alu_op        = 2'b00;
        w_alu_sel_src_a = 2'b00;
        w_alu_sel_src_b = 1'b0;
        case (opcode_q)
            c_op_load, c_op_store, c_op_jalr: begin
                w_alu_sel_src_b = 1'b1;
            end
            c_op_imm, c_op_imm_32: begin
                w_alu_op        = 2'b10;
                w_alu_sel_src_b = 1'b1;
            end
            c_op_reg, c_op_32: begin
                w_alu_op        = 2'b10;
            end
            c_op_auipc, c_op_jal: begin
                w_alu_sel_src_a = 2'b01;
                w_alu_sel_src_b = 1'b1;
            end
            c_op_lui: begin
                w_alu_sel_src_a = 2'b10;
                w_alu_sel_src_b = 1'b1;
            end
            c_op_branch: begin
                w_alu_op        = 2'b11;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d                 = state_q;
        opcode_d                = opcode_q;
        w_inst_mem_req          = 1'b0;
        w_ir_write_enable       = 1'b0;
        w_pc_write_enable       = 1'b0;
        w_jal_enable            = 1'b0;
        w_jalr_enable           = 1'b0;
        w_branch_enable         = 1'b0;
        w_data_mem_read_enable  = 1'b0;
        w_data_mem_write_enable = 1'b0;
        w_regfile_write_enable  = 1'b0;
        w_mem_to_reg_sel        = 2'b00;
        w_alu_active            = 1'b0;
        w_fault                 = 1'b0;

        case (state_q)
            S_FETCH: begin
                w_inst_mem_req = 1'b1;
                if (bus.inst_mem_ready) begin
                    w_ir_write_enable = 1'b1;
                    state_d           = S_DECODE;
                end
`ifdef CONTROL_MULTICYCLE_FAULT_EN
                else if (w_timeout) begin
                    state_d = S_FAULT;
                end
`endif
            end

            S_DECODE: begin
                opcode_d = bus.inst_opcode;
                if (f_is_legal(bus.inst_opcode)) begin
                    state_d = S_EXECUTE;
                end else begin
`ifdef CONTROL_MULTICYCLE_FAULT_EN
                    state_d = S_FAULT;
`else
                    // Illegal opcodes retire as a NOP by advancing the PC.
                    w_pc_write_enable = 1'b1;
                    state_d           = S_FETCH;
`endif
                end
            end

            S_EXECUTE: begin
                w_alu_active = 1'b1;
                case (opcode_q)
                    c_op_branch: begin
                        w_pc_write_enable = 1'b1;
                        w_branch_enable   = 1'b1;
                        state_d           = S_FETCH;
                    end
                    c_op_load, c_op_store: state_d = S_MEM;
                    default:               state_d = S_WRITEBACK;
                endcase
            end

            S_MEM: begin
                w_alu_active = 1'b1;
                if (opcode_q == c_op_store) begin
                    w_data_mem_write_enable = 1'b1;
                end else begin
                    w_data_mem_read_enable  = 1'b1;
                end
                if (bus.data_mem_ready) begin
                    if (opcode_q == c_op_store) begin
                        w_pc_write_enable = 1'b1;
                        state_d           = S_FETCH;
                    end else begin
                        state_d           = S_WRITEBACK;
                    end
                end
`ifdef CONTROL_MULTICYCLE_FAULT_EN
                else if (w_timeout) begin
                    state_d = S_FAULT;
                end
`endif
            end

            S_WRITEBACK: begin
                w_alu_active           = 1'b1;
                w_regfile_write_enable = 1'b1;
                w_pc_write_enable      = 1'b1;
                w_mem_to_reg_sel       = (opcode_q == c_op_load) ? 2'b01 : 2'b00;
                w_jal_enable           = (opcode_q == c_op_jal);
                w_jalr_enable          = (opcode_q == c_op_jalr);
                state_d                = S_FETCH;
            end

            S_FAULT: begin
`ifdef CONTROL_MULTICYCLE_FAULT_EN
                w_fault = 1'b1;
`endif
            end

            default: state_d = S_FETCH;
        endcase
    end

    // Reset forces every output low immediately, abandoning any open request.
    assign bus.inst_mem_req          = w_inst_mem_req          & ~rst;
    assign bus.ir_write_enable       = w_ir_write_enable       & ~rst;
    assign bus.pc_write_enable       = w_pc_write_enable       & ~rst;
    assign bus.jal_enable            = w_jal_enable            & ~rst;
    assign bus.jalr_enable           = w_jalr_enable           & ~rst;
    assign bus.branch_enable         = w_branch_enable         & ~rst;
    assign bus.data_mem_read_enable  = w_data_mem_read_enable  & ~rst;
    assign bus.data_mem_write_enable = w_data_mem_write_enable & ~rst;
    assign bus.regfile_write_enable  = w_regfile_write_enable  & ~rst;
    assign bus.mem_to_reg_sel        = rst ? 2'b00 : w_mem_to_reg_sel;
    assign bus.alu_op                = (rst || !w_alu_active) ? 2'b00 : w_alu_op;
    assign bus.alu_sel_src_a         = (rst || !w_alu_active) ? 2'b00 : w_alu_sel_src_a;
    assign bus.alu_sel_src_b         = w_alu_sel_src_b & w_alu_active & ~rst;
    assign bus.state                 = rst ? 3'd0 : state_q;
    assign bus.fault                 = w_fault & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_control_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_multicycle
// Description : Directed scoreboard bench for control_multicycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_multicycle;

    localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2,
                           ST_M = 3'd3, ST_W = 3'd4, ST_X = 3'd5;

    // Enable field order: req, ir_we, pc_we, branch, jal, jalr, rd, wr, rf_we
    localparam logic [8:0] EN_NONE  = 9'b000000000;
    localparam logic [8:0] EN_FRDY  = 9'b110000000;
    localparam logic [8:0] EN_FWAIT = 9'b100000000;
    localparam logic [8:0] EN_WB    = 9'b001000001;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_32    = 7'b0111011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_ILL   = 7'b0001011;

    typedef struct {
        string       tag;
        logic [19:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb[$];

    control_multicycle_if bus_if();

    control_multicycle #(
        .MEM_WAIT_MAX (4),
        .ENABLE_RV64  (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input logic [2:0] st, input logic [8:0] en,
                                       input logic [1:0] m2r, input logic [1:0] aop,
                                       input logic [1:0] sa, input logic sbb,
                                       input logic flt);
        return {st, en, m2r, aop, sa, sbb, flt};
    endfunction

    task automatic check_front();
        exp_t        e;
        logic [19:0] obs;
        obs = {bus_if.state, bus_if.inst_mem_req, bus_if.ir_write_enable,
               bus_if.pc_write_enable, bus_if.branch_enable, bus_if.jal_enable,
               bus_if.jalr_enable, bus_if.data_mem_read_enable,
               bus_if.data_mem_write_enable, bus_if.regfile_write_enable,
               bus_if.mem_to_reg_sel, bus_if.alu_op, bus_if.alu_sel_src_a,
               bus_if.alu_sel_src_b, bus_if.fault};
        e = sb.pop_front();
        checks++;
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h", e.tag, obs, e.val);
        end
    endtask

    task automatic cyc(input string tag, input logic r, input logic [6:0] op,
                       input logic ir, input logic dr, input logic [19:0] exp);
        @(negedge clk);
        rst                   = r;
        bus_if.inst_opcode    = op;
        bus_if.inst_mem_ready = ir;
        bus_if.data_mem_ready = dr;
        sb.push_back('{tag: tag, val: exp});
        #1;
        check_front();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst                   = 1'b1;
        bus_if.inst_opcode    = 7'd0;
        bus_if.inst_mem_ready = 1'b0;
        bus_if.data_mem_ready = 1'b0;

        cyc("reset_0", 1, OP_REG, 1, 1, 20'h0);
        cyc("reset_1", 1, OP_REG, 1, 1, 20'h0);

        // ADD: F, D, E, WB
        cyc("add_fetch",  0, OP_REG, 1, 1, mk(ST_F, EN_FRDY, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("add_decode", 0, OP_REG, 1, 1, mk(ST_D, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("add_exec",   0, OP_REG, 1, 1, mk(ST_E, EN_NONE, 2'b00, 2'b10, 2'b00, 0, 0));
        cyc("add_wb",     0, OP_REG, 1, 1, mk(ST_W, EN_WB,   2'b00, 2'b10, 2'b00, 0, 0));

        // LOAD with three data wait cycles
        cyc("ld_fetch",  0, OP_LOAD, 1, 1, mk(ST_F, EN_FRDY, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("ld_decode", 0, OP_LOAD, 1, 1, mk(ST_D, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("ld_exec",   0, OP_LOAD, 1, 0, mk(ST_E, EN_NONE, 2'b00, 2'b00, 2'b00, 1, 0));
        for (int i = 0; i < 3; i++)
            cyc("ld_mem_wait", 0, OP_LOAD, 1, 0, mk(ST_M, 9'b000000100, 2'b00, 2'b00, 2'b00, 1, 0));
        cyc("ld_mem_done", 0, OP_LOAD, 1, 1, mk(ST_M, 9'b000000100, 2'b00, 2'b00, 2'b00, 1, 0));
        cyc("ld_wb",       0, OP_LOAD, 1, 1, mk(ST_W, EN_WB,       2'b01, 2'b00, 2'b00, 1, 0));

        // BEQ: commits in EXECUTE, no register write
        cyc("beq_fetch",  0, OP_BR, 1, 1, mk(ST_F, EN_FRDY, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("beq_decode", 0, OP_BR, 1, 1, mk(ST_D, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("beq_exec",   0, OP_BR, 1, 1, mk(ST_E, 9'b001100000, 2'b00, 2'b11, 2'b00, 0, 0));

        // JAL
        cyc("jal_fetch",  0, OP_JAL, 1, 1, mk(ST_F, EN_FRDY, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("jal_decode", 0, OP_JAL, 1, 1, mk(ST_D, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("jal_exec",   0, OP_JAL, 1, 1, mk(ST_E, EN_NONE, 2'b00, 2'b00, 2'b01, 1, 0));
        cyc("jal_wb",     0, OP_JAL, 1, 1, mk(ST_W, 9'b001010001, 2'b00, 2'b00, 2'b01, 1, 0));

        // JALR
        cyc("jalr_fetch",  0, OP_JALR, 1, 1, mk(ST_F, EN_FRDY, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("jalr_decode", 0, OP_JALR, 1, 1, mk(ST_D, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("jalr_exec",   0, OP_JALR, 1, 1, mk(ST_E, EN_NONE, 2'b00, 2'b00, 2'b00, 1, 0));
        cyc("jalr_wb",     0, OP_JALR, 1, 1, mk(ST_W, 9'b001001001, 2'b00, 2'b00, 2'b00, 1, 0));

        // LUI
        cyc("lui_fetch",  0, OP_LUI, 1, 1, mk(ST_F, EN_FRDY, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("lui_decode", 0, OP_LUI, 1, 1, mk(ST_D, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("lui_exec",   0, OP_LUI, 1, 1, mk(ST_E, EN_NONE, 2'b00, 2'b00, 2'b10, 1, 0));
        cyc("lui_wb",     0, OP_LUI, 1, 1, mk(ST_W, EN_WB,   2'b00, 2'b00, 2'b10, 1, 0));

        // STORE, zero wait: commits in MEM
        cyc("st_fetch",  0, OP_STORE, 1, 1, mk(ST_F, EN_FRDY, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("st_decode", 0, OP_STORE, 1, 1, mk(ST_D, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("st_exec",   0, OP_STORE, 1, 1, mk(ST_E, EN_NONE, 2'b00, 2'b00, 2'b00, 1, 0));
        cyc("st_mem",    0, OP_STORE, 1, 1, mk(ST_M, 9'b001000010, 2'b00, 2'b00, 2'b00, 1, 0));

        // OP_32 is legal with RV64 enabled
        cyc("op32_fetch",  0, OP_32, 1, 1, mk(ST_F, EN_FRDY, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("op32_decode", 0, OP_32, 1, 1, mk(ST_D, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("op32_exec",   0, OP_32, 1, 1, mk(ST_E, EN_NONE, 2'b00, 2'b10, 2'b00, 0, 0));
        cyc("op32_wb",     0, OP_32, 1, 1, mk(ST_W, EN_WB,   2'b00, 2'b10, 2'b00, 0, 0));

        // OP_IMM behind a short fetch stall
        for (int i = 0; i < 2; i++)
            cyc("imm_fetch_wait", 0, OP_IMM, 0, 1, mk(ST_F, EN_FWAIT, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("imm_fetch",  0, OP_IMM, 1, 1, mk(ST_F, EN_FRDY, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("imm_decode", 0, OP_IMM, 1, 1, mk(ST_D, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("imm_exec",   0, OP_IMM, 1, 1, mk(ST_E, EN_NONE, 2'b00, 2'b10, 2'b00, 1, 0));
        cyc("imm_wb",     0, OP_IMM, 1, 1, mk(ST_W, EN_WB,   2'b00, 2'b10, 2'b00, 1, 0));

        // Illegal opcode
        cyc("ill_fetch", 0, OP_ILL, 1, 1, mk(ST_F, EN_FRDY, 2'b00, 2'b00, 2'b00, 0, 0));
`ifdef CONTROL_MULTICYCLE_FAULT_EN
        cyc("ill_decode", 0, OP_ILL, 1, 1, mk(ST_D, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        for (int i = 0; i < 20; i++)
            cyc("ill_fault_hold", 0, OP_ILL, i[0], ~i[0], mk(ST_X, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 1));
        cyc("ill_reset", 1, OP_REG, 1, 1, 20'h0);

        // Fetch timeout after MEM_WAIT_MAX = 4
        for (int i = 0; i < 5; i++)
            cyc("to_fetch_wait", 0, OP_REG, 0, 0, mk(ST_F, EN_FWAIT, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("to_fault_0", 0, OP_REG, 0, 0, mk(ST_X, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 1));
        cyc("to_fault_1", 0, OP_REG, 1, 1, mk(ST_X, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 1));
        cyc("to_reset",   1, OP_REG, 1, 1, 20'h0);
        for (int i = 0; i < 4; i++)
            cyc("edge_fetch_wait", 0, OP_REG, 0, 0, mk(ST_F, EN_FWAIT, 2'b00, 2'b00, 2'b00, 0, 0));
`else
        cyc("ill_decode_nop", 0, OP_ILL, 1, 1, mk(ST_D, 9'b001000000, 2'b00, 2'b00, 2'b00, 0, 0));
        for (int i = 0; i < 8; i++)
            cyc("long_fetch_wait", 0, OP_REG, 0, 0, mk(ST_F, EN_FWAIT, 2'b00, 2'b00, 2'b00, 0, 0));
`endif
        cyc("edge_fetch",  0, OP_REG, 1, 0, mk(ST_F, EN_FRDY, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("edge_decode", 0, OP_REG, 1, 0, mk(ST_D, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("edge_exec",   0, OP_REG, 1, 0, mk(ST_E, EN_NONE, 2'b00, 2'b10, 2'b00, 0, 0));
        cyc("edge_wb",     0, OP_REG, 1, 0, mk(ST_W, EN_WB,   2'b00, 2'b10, 2'b00, 0, 0));

        // Reset in the middle of a stalled STORE
        cyc("rs_fetch",  0, OP_STORE, 1, 0, mk(ST_F, EN_FRDY, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("rs_decode", 0, OP_STORE, 1, 0, mk(ST_D, EN_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc("rs_exec",   0, OP_STORE, 1, 0, mk(ST_E, EN_NONE, 2'b00, 2'b00, 2'b00, 1, 0));
        cyc("rs_mem",    0, OP_STORE, 1, 0, mk(ST_M, 9'b000000010, 2'b00, 2'b00, 2'b00, 1, 0));
        cyc("rs_assert", 1, OP_STORE, 1, 0, 20'h0);
        cyc("rs_release", 0, OP_STORE, 0, 0, mk(ST_F, EN_FWAIT, 2'b00, 2'b00, 2'b00, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
